instbuffer: RTL and testbench

Parametrised instruction buffer between instruction fetch and the decoder; successor to the fixed 8-entry instruction queue. Buffers fetched instructions with their PC and predicted-taken bit and issues one per cycle to the decoder when the reservation station and reorder buffer are both ready. Adds the following:
- Configurable depth with full DEPTH-entry utilisation.
- An occupancy count and a credit-slack ready signal for the fetch pipeline.
- A multi-source flush vector.
- A sticky overflow flag.
- An optional empty-queue bypass.

---
 rtl/instbuffer_pkg.sv | 15 +
 rtl/instbuffer_mem.sv | 29 ++
 rtl/instbuffer.sv | 127 ++++++++++++
 tb/tb_instbuffer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/instbuffer_pkg.sv
// instbuffer_pkg: constants shared by the instruction buffer and its storage.
//   ID_WIDTH      default instruction width
//   ADDRESS_WIDTH default PC width
//   NOP           value presented on the decoder port after reset
// Entry packing order everywhere is {pred_taken, pc, inst}.
package instbuffer_pkg;
  localparam int          ID_WIDTH      = 32;
  localparam int          ADDRESS_WIDTH = 32;
  localparam logic [31:0] NOP           = 32'h00000013;

  // Width of one packed {pred_taken, pc, inst} entry.
  function automatic int entry_w(input int iw, input int aw);
    return iw + aw + 1;
  endfunction
endpackage

// File: rtl/instbuffer_mem.sv
// instbuffer_mem: DEPTH x EW register array for the instruction buffer.
// Ports:
//   clk_in   clock
//   i_we     write enable (already qualified by accept/enable in the parent)
//   i_waddr  write index (tail)
//   i_wdata  packed entry {pred_taken, pc, inst}
//   i_raddr  read index (head)
//   o_rdata  combinational read data at i_raddr
// Storage has no reset; contents are don't-care until written.
module instbuffer_mem #(
  parameter int DEPTH = 8,
  parameter int EW    = 65,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          i_we,
  input  logic [PW-1:0] i_waddr,
  input  logic [EW-1:0] i_wdata,
  input  logic [PW-1:0] i_raddr,
  output logic [EW-1:0] o_rdata
);
  logic [EW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instbuffer.sv
// instbuffer: instruction buffer between fetch and decode.
// Buffers {inst, pc, pred_taken} and issues one entry per cycle when
// issue_rdy_in is high. The count register is the only full/empty source.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable)
//   if_en_in/if_inst_in/if_pc_in/if_pred_taken_in  enqueue side
//   if_rdy_out        high iff count + AFULL_SLACK < DEPTH
//   flush_in          any bit set empties the buffer
//   issue_rdy_in      downstream ready
//   dec_*_out         registered issue strobe and data
//   count_out         occupancy
//   overflow_err_out  sticky: enqueue attempted while full
// Optional feature: define INSTQ_BYPASS_EN to let an instruction arriving at
// an empty buffer with issue_rdy_in high go straight to the output registers.
module instbuffer
  import instbuffer_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int INST_WIDTH  = ID_WIDTH,
  parameter int ADDR_WIDTH  = ADDRESS_WIDTH,
  parameter int AFULL_SLACK = 1,
  parameter int FLUSH_SRCS  = 3,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  if_en_in,
  input  logic [INST_WIDTH-1:0] if_inst_in,
  input  logic [ADDR_WIDTH-1:0] if_pc_in,
  input  logic                  if_pred_taken_in,
  output logic                  if_rdy_out,
  input  logic [FLUSH_SRCS-1:0] flush_in,
  input  logic                  issue_rdy_in,
  output logic                  dec_en_out,
  output logic [INST_WIDTH-1:0] dec_inst_out,
  output logic [ADDR_WIDTH-1:0] dec_pc_out,
  output logic                  dec_pred_taken_out,
  output logic [CW-1:0]         count_out,
  output logic                  overflow_err_out
);
  localparam int EW = entry_w(INST_WIDTH, ADDR_WIDTH);

  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_dec_en;
  logic [INST_WIDTH-1:0] r_dec_inst;
  logic [ADDR_WIDTH-1:0] r_dec_pc;
  logic                  r_dec_pred;

  logic          w_flush, w_full, w_empty;
  logic          w_bypass, w_accept, w_deq, w_we;
  logic [EW-1:0] w_wdata, w_rdata, w_out;

  assign w_flush = |flush_in;
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_wdata = {if_pred_taken_in, if_pc_in, if_inst_in};

`ifdef INSTQ_BYPASS_EN
  // Empty buffer and a ready consumer: skip storage, pointers stay put.
  assign w_bypass = w_empty && if_en_in && issue_rdy_in && !w_flush;
  assign w_out    = w_bypass ? w_wdata : w_rdata;
`else
  assign w_bypass = 1'b0;
  assign w_out    = w_rdata;
`endif

  // Both decisions use the pre-edge count: a same-cycle dequeue never
  // frees a slot for the enqueue.
  assign w_accept = if_en_in && !w_full && !w_flush && !w_bypass;
  assign w_deq    = issue_rdy_in && !w_empty && !w_flush;
  assign w_we     = rdy_in && !rst_in && w_accept;

  instbuffer_mem #(.DEPTH(DEPTH), .EW(EW)) u_mem (
    .clk_in  (clk_in),
    .i_we    (w_we),
    .i_waddr (r_tail),
    .i_wdata (w_wdata),
    .i_raddr (r_head),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_dec_en   <= 1'b0;
      r_dec_inst <= INST_WIDTH'(NOP);
      r_dec_pc   <= '0;
      r_dec_pred <= 1'b0;
    end else if (rdy_in) begin
      if (w_flush) begin
        // Data outputs and the overflow flag deliberately hold.
        r_head   <= '0;
        r_tail   <= '0;
        r_count  <= '0;
        r_dec_en <= 1'b0;
      end else begin
        if (if_en_in && w_full) r_ovf <= 1'b1;
        if (w_accept) r_tail <= r_tail + 1'b1;
        if (w_deq)    r_head <= r_head + 1'b1;
        r_count <= r_count + CW'(w_accept) - CW'(w_deq);
        if (w_deq || w_bypass) begin
          r_dec_en   <= 1'b1;
          r_dec_inst <= w_out[INST_WIDTH-1:0];
          r_dec_pc   <= w_out[INST_WIDTH +: ADDR_WIDTH];
          r_dec_pred <= w_out[EW-1];
        end else begin
          r_dec_en <= 1'b0;
        end
      end
    end
  end

  assign if_rdy_out         = (32'(r_count) + 32'(AFULL_SLACK)) < 32'(DEPTH);
  assign count_out          = r_count;
  assign overflow_err_out   = r_ovf;
  assign dec_en_out         = r_dec_en;
  assign dec_inst_out       = r_dec_inst;
  assign dec_pc_out         = r_dec_pc;
  assign dec_pred_taken_out = r_dec_pred;
endmodule

// File: tb/tb_instbuffer.sv
module tb_instbuffer;
  localparam int DEPTH = 8;
  localparam int SLACK = 1;
  localparam int IW = 32;
  localparam int AW = 32;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          pred;
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1, rdy = 1'b1, en = 1'b0, pred = 1'b0, issue = 1'b0;
  logic [IW-1:0] inst = '0;
  logic [AW-1:0] pc = '0;
  logic [2:0]    flush = '0;
  logic          if_rdy, dec_en, dec_pred, ovf;
  logic [IW-1:0] dec_inst;
  logic [AW-1:0] dec_pc;
  logic [CW-1:0] cnt;

  instbuffer #(.DEPTH(DEPTH), .INST_WIDTH(IW), .ADDR_WIDTH(AW),
               .AFULL_SLACK(SLACK), .FLUSH_SRCS(3)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .if_en_in(en), .if_inst_in(inst), .if_pc_in(pc), .if_pred_taken_in(pred),
    .if_rdy_out(if_rdy), .flush_in(flush), .issue_rdy_in(issue),
    .dec_en_out(dec_en), .dec_inst_out(dec_inst), .dec_pc_out(dec_pc),
    .dec_pred_taken_out(dec_pred), .count_out(cnt), .overflow_err_out(ovf)
  );

  always #5 clk = ~clk;

  // Reference model: plain queue plus the visible output registers.
  ent_t q[$];
  logic m_ovf = 1'b0, m_en = 1'b0;
  ent_t m_out = '0;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    ent_t in_e, popped;
    bit acc, deq, byp;
    in_e = '{pred: pred, pc: pc, inst: inst};
    if (rst) begin
      q.delete(); m_ovf = 0; m_en = 0;
      m_out = '{pred: 1'b0, pc: '0, inst: 32'h00000013};
    end else if (rdy) begin
      if (flush != 0) begin
        q.delete(); m_en = 0;
      end else begin
        byp = 0;
`ifdef INSTQ_BYPASS_EN
        byp = (q.size() == 0) && en && issue;
`endif
        if (byp) begin
          m_en = 1; m_out = in_e;
        end else begin
          acc = en && (q.size() < DEPTH);
          deq = issue && (q.size() != 0);
          if (en && q.size() == DEPTH) m_ovf = 1;
          if (deq) begin popped = q.pop_front(); m_out = popped; m_en = 1; end
          else m_en = 0;
          if (acc) q.push_back(in_e);
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("count", 64'(cnt), 64'(q.size()));
    chk("if_rdy", 64'(if_rdy), 64'((q.size() + SLACK) < DEPTH));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("dec_en", 64'(dec_en), 64'(m_en));
    chk("dec_inst", 64'(dec_inst), 64'(m_out.inst));
    chk("dec_pc", 64'(dec_pc), 64'(m_out.pc));
    chk("dec_pred", 64'(dec_pred), 64'(m_out.pred));
  endtask

  task automatic drive(input bit e, input bit iss, input logic [AW-1:0] p);
    en = e; issue = iss; pc = p; inst = $urandom; pred = p[2];
    tick();
  endtask

  initial begin
    // Reset (also with rdy low: reset must still act).
    rst = 1; rdy = 0; tick(); tick();
    rst = 0; rdy = 1;

    // Fill to full, then one more enqueue to trip the sticky flag.
    for (int i = 0; i < DEPTH; i++) drive(1, 0, 32'h1000 + 4 * i);
    drive(1, 0, 32'h2000);
    drive(0, 0, 0);
    chk("ovf_sticky", 64'(ovf), 64'(1));
    // Full with enqueue + dequeue: enqueue dropped, count falls by one.
    drive(1, 1, 32'h3000);
    drive(0, 1, 0); drive(0, 1, 0);
    chk("count_at5", 64'(cnt), 64'(5));
    drive(1, 1, 32'h3004);
    chk("count_hold5", 64'(cnt), 64'(5));
    drive(0, 0, 0);

    // Ordered issue of four entries.
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 4; i++) drive(1, 0, 32'h100 + 4 * i);
    for (int i = 0; i < 5; i++) drive(0, 1, 0);

    // Flush at count 6 with a same-cycle enqueue.
    for (int i = 0; i < 6; i++) drive(1, 0, 32'h400 + 4 * i);
    flush = 3'b010; drive(1, 0, 32'h500); flush = '0;
    chk("flush_cnt", 64'(cnt), 64'(0));
    drive(1, 0, 32'h600); drive(1, 0, 32'h604);
    drive(0, 1, 0); drive(0, 1, 0); drive(0, 1, 0);

    // Empty-queue enqueue with issue ready: bypass latency.
    drive(1, 1, 32'h200);
    drive(0, 1, 0); drive(0, 1, 0);

    // Global stall mid-stream.
    for (int i = 0; i < 4; i++) drive(1, 1, 32'h700 + 4 * i);
    rdy = 0;
    for (int i = 0; i < 3; i++) drive(1, 1, 32'h800 + 4 * i);
    rdy = 1;
    for (int i = 0; i < 6; i++) drive(0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 5, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
